// File: rtl/mem_stage.sv
// mem_stage -- memory access stage of a simple in-order pipeline.
//
// Loads and stores occupy the stage for MEM_LATENCY cycles. While the stage
// is busy it raises stall_out and the ALU stage holds its outputs. Every
// other instruction passes straight through with a one-cycle latency.
// Results are registered.
//
// Parameters
//   MEM_WORDS    data memory depth in 32-bit words (power of two, >= 2)
//   MEM_LATENCY  cycles a load/store occupies the stage (1..15)
//
// Ports
//   clk              single clock, rising edge
//   reset            synchronous, active-high
//   valid_in         upstream holds a valid instruction
//   instruction_in   instruction (opcode [6:0], funct3 [14:12])
//   alu_result       effective address for load/store, else writeback value
//   store_data       rs2 value for stores
//   stall_out        stage busy (combinational from the FSM state)
//   valid_out        instruction_out / wb_data valid this cycle
//   instruction_out  instruction forwarded to writeback
//   wb_data          writeback value
//   exception_out    misaligned word access flag
//
// Build option
//   MEM_STAGE_MISALIGN_TRAP_EN  when defined, a word load/store whose
//   address[1:0] is nonzero is not performed. It completes on the next edge
//   with exception_out=1 and wb_data=0. When undefined, the low address bits
//   are ignored for word accesses and exception_out is always 0.
module mem_stage #(
  parameter int MEM_WORDS   = 256,
  parameter int MEM_LATENCY = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_in,
  input  logic [31:0] instruction_in,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  output logic        stall_out,
  output logic        valid_out,
  output logic [31:0] instruction_out,
  output logic [31:0] wb_data,
  output logic        exception_out
);

  localparam int IDX_W  = $clog2(MEM_WORDS);
  localparam int ADDR_W = IDX_W + 2;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [2:0] F3_BYTE   = 3'b000;
  localparam logic [2:0] F3_BYTE_U = 3'b100;
  localparam logic [3:0] CNT_START = 4'(MEM_LATENCY - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Select one little-endian byte lane of a word.
  function automatic logic [7:0] byte_lane(input logic [31:0] word,
                                           input logic [1:0]  lane);
    logic [7:0] b;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      2'd3:    b = word[31:24];
      default: b = word[7:0];
    endcase
    return b;
  endfunction

  // Shape the raw memory word into the load result. Unknown funct3 values
  // behave as LW.
  function automatic logic [31:0] load_format(input logic [31:0] word,
                                              input logic [2:0]  f3,
                                              input logic [1:0]  lane);
    logic [7:0]  b;
    logic [31:0] r;
    b = byte_lane(word, lane);
    case (f3)
      F3_BYTE:   r = {{24{b[7]}}, b};
      F3_BYTE_U: r = {24'd0, b};
      default:   r = word;
    endcase
    return r;
  endfunction

  // Build the word written back to memory. For SB, only the addressed lane
  // changes. Unknown funct3 values behave as SW.
  function automatic logic [31:0] store_merge(input logic [31:0] old_word,
                                              input logic [31:0] data,
                                              input logic [2:0]  f3,
                                              input logic [1:0]  lane);
    logic [31:0] r;
    r = old_word;
    case (f3)
      F3_BYTE: begin
        case (lane)
          2'd0:    r[7:0]   = data[7:0];
          2'd1:    r[15:8]  = data[7:0];
          2'd2:    r[23:16] = data[7:0];
          2'd3:    r[31:24] = data[7:0];
          default: r = old_word;
        endcase
      end
      default: r = data;
    endcase
    return r;
  endfunction

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
  // True for the word-sized load/store forms (everything except LB/LBU/SB).
  function automatic logic is_word_access(input logic [6:0] op,
                                          input logic [2:0] f3);
    logic w;
    case (op)
      OP_LOAD:  w = (f3 != F3_BYTE) && (f3 != F3_BYTE_U);
      OP_STORE: w = (f3 != F3_BYTE);
      default:  w = 1'b0;
    endcase
    return w;
  endfunction
`endif

  state_t              state_r;
  state_t              state_s;
  logic [3:0]          cnt_r;
  logic [3:0]          cnt_s;
  logic [31:0]         lat_instr_r;
  logic [31:0]         lat_instr_s;
  logic [ADDR_W-1:0]   lat_addr_r;
  logic [ADDR_W-1:0]   lat_addr_s;
  logic [31:0]         lat_data_r;
  logic [31:0]         lat_data_s;
  logic                valid_s;
  logic [31:0]         instr_s;
  logic [31:0]         wb_s;
  logic                exc_s;

  logic                in_is_mem_s;
  logic                trap_s;
  logic [IDX_W-1:0]    mem_idx_s;
  logic [1:0]          lane_s;
  logic [2:0]          lat_f3_s;
  logic [31:0]         rd_word_s;
  logic                mem_we_s;
  logic [31:0]         mem_wdata_s;

  logic [31:0]         mem_r [MEM_WORDS];

  assign stall_out   = (state_r == BUSY);
  assign in_is_mem_s = (instruction_in[6:0] == OP_LOAD) ||
                       (instruction_in[6:0] == OP_STORE);

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
  assign trap_s = in_is_mem_s &&
                  is_word_access(instruction_in[6:0], instruction_in[14:12]) &&
                  (alu_result[1:0] != 2'b00);
`else
  assign trap_s = 1'b0;
`endif

  // Upper address bits were already dropped at latch time, so the index wraps
  // modulo the memory size.
  assign mem_idx_s = lat_addr_r[ADDR_W-1:2];
  assign lane_s    = lat_addr_r[1:0];
  assign lat_f3_s  = lat_instr_r[14:12];
  assign rd_word_s = mem_r[mem_idx_s];

  // Next-state, latch and output decisions for the IDLE/BUSY controller
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    lat_instr_s = lat_instr_r;
    lat_addr_s  = lat_addr_r;
    lat_data_s  = lat_data_r;
    valid_s     = 1'b0;
    instr_s     = instruction_out;
    wb_s        = wb_data;
    exc_s       = exception_out;
    mem_we_s    = 1'b0;
    mem_wdata_s = store_merge(rd_word_s, lat_data_r, lat_f3_s, lane_s);

    case (state_r)
      IDLE: begin
        if (valid_in) begin
          if (trap_s) begin
            // Misaligned word access: report it at once and do not touch memory.
            valid_s = 1'b1;
            instr_s = instruction_in;
            wb_s    = 32'd0;
            exc_s   = 1'b1;
          end else if (in_is_mem_s) begin
            state_s     = BUSY;
            cnt_s       = CNT_START;
            lat_instr_s = instruction_in;
            lat_addr_s  = alu_result[ADDR_W-1:0];
            lat_data_s  = store_data;
          end else begin
            valid_s = 1'b1;
            instr_s = instruction_in;
            wb_s    = alu_result;
            exc_s   = 1'b0;
          end
        end else begin
          state_s = IDLE;
        end
      end
      BUSY: begin
        if (cnt_r != 4'd0) begin
          cnt_s = cnt_r - 4'd1;
        end else begin
          // The memory access happens only on this completion edge.
          state_s = IDLE;
          valid_s = 1'b1;
          instr_s = lat_instr_r;
          exc_s   = 1'b0;
          if (lat_instr_r[6:0] == OP_STORE) begin
            mem_we_s = 1'b1;
            wb_s     = 32'd0;
          end else begin
            wb_s = load_format(rd_word_s, lat_f3_s, lane_s);
          end
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // FSM state, latched operands and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r         <= IDLE;
      cnt_r           <= 4'd0;
      lat_instr_r     <= 32'd0;
      lat_addr_r      <= {ADDR_W{1'b0}};
      lat_data_r      <= 32'd0;
      valid_out       <= 1'b0;
      instruction_out <= 32'd0;
      wb_data         <= 32'd0;
      exception_out   <= 1'b0;
    end else begin
      state_r         <= state_s;
      cnt_r           <= cnt_s;
      lat_instr_r     <= lat_instr_s;
      lat_addr_r      <= lat_addr_s;
      lat_data_r      <= lat_data_s;
      valid_out       <= valid_s;
      instruction_out <= instr_s;
      wb_data         <= wb_s;
      exception_out   <= exc_s;
    end
  end

  // Data memory write port. Contents survive reset, and a reset on the
  // completion edge aborts the store.
  always_ff @(posedge clk) begin
    if (mem_we_s && !reset) begin
      mem_r[mem_idx_s] <= mem_wdata_s;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage -- self-checking bench for mem_stage.
// A byte-addressed reference memory predicts load results, completion
// latency and stall duration. It covers directed cases followed by
// randomized traffic. Build option MEM_STAGE_MISALIGN_TRAP_EN is honoured
// when it is defined.
module tb_mem_stage;

  localparam int MEM_WORDS   = 256;
  localparam int MEM_LATENCY = 5;
  localparam int MEM_BYTES   = MEM_WORDS * 4;

  localparam logic [6:0] LOAD  = 7'b0000011;
  localparam logic [6:0] STORE = 7'b0100011;
  localparam logic [6:0] ALU   = 7'b0110011;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_in;
  logic [31:0] instruction_in;
  logic [31:0] alu_result;
  logic [31:0] store_data;
  logic        stall_out;
  logic        valid_out;
  logic [31:0] instruction_out;
  logic [31:0] wb_data;
  logic        exception_out;

  int checks   = 0;
  int failures = 0;

  logic [7:0]  mdl [MEM_BYTES];
  logic [31:0] last_wb;
  logic [31:0] last_instr;
  logic        last_exc;

  always #5 clk = ~clk;

  mem_stage #(.MEM_WORDS(MEM_WORDS), .MEM_LATENCY(MEM_LATENCY)) dut (
    .clk(clk),
    .reset(reset),
    .valid_in(valid_in),
    .instruction_in(instruction_in),
    .alu_result(alu_result),
    .store_data(store_data),
    .stall_out(stall_out),
    .valid_out(valid_out),
    .instruction_out(instruction_out),
    .wb_data(wb_data),
    .exception_out(exception_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk_instr(input logic [6:0] op, input logic [2:0] f3);
    logic [31:0] r;
    r        = $urandom;
    r[6:0]   = op;
    r[14:12] = f3;
    return r;
  endfunction

  // Reference behaviour. It predicts the result and the number of edges after
  // acceptance, and it updates the byte memory for stores.
  task automatic model_op(input logic [31:0] instr, input logic [31:0] addr,
                          input logic [31:0] sd, output logic [31:0] exp_wb,
                          output logic exp_exc, output int exp_lat);
    int ba;
    int base;
    logic [6:0] op;
    logic [2:0] f3;
    op      = instr[6:0];
    f3      = instr[14:12];
    ba      = int'(addr % MEM_BYTES);
    base    = ba - (ba % 4);
    exp_wb  = addr;
    exp_exc = 1'b0;
    exp_lat = 0;
    if (op == LOAD || op == STORE) begin
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
      begin
        logic word_acc;
        word_acc = (op == LOAD) ? (f3 != 3'b000 && f3 != 3'b100) : (f3 != 3'b000);
        if (word_acc && (ba % 4) != 0) begin
          exp_wb  = 32'd0;
          exp_exc = 1'b1;
          return;
        end
      end
`endif
      exp_lat = MEM_LATENCY;
      if (op == LOAD) begin
        if (f3 == 3'b000)      exp_wb = {{24{mdl[ba][7]}}, mdl[ba]};
        else if (f3 == 3'b100) exp_wb = {24'd0, mdl[ba]};
        else exp_wb = {mdl[base+3], mdl[base+2], mdl[base+1], mdl[base]};
      end else begin
        exp_wb = 32'd0;
        if (f3 == 3'b000) mdl[ba] = sd[7:0];
        else for (int i = 0; i < 4; i++) mdl[base+i] = sd[8*i +: 8];
      end
    end
  endtask

  // Present one instruction just after a rising edge and follow it to completion.
  task automatic run_op(input string tag, input logic [31:0] instr,
                        input logic [31:0] addr, input logic [31:0] sd);
    logic [31:0] exp_wb;
    logic        exp_exc;
    int          exp_lat;
    int          edges;
    int          stall_cnt;
    model_op(instr, addr, sd, exp_wb, exp_exc, exp_lat);
    valid_in       = 1'b1;
    instruction_in = instr;
    alu_result     = addr;
    store_data     = sd;
    chk({tag, "/stall_before"}, 32'(stall_out), 32'd0);
    @(posedge clk); #1;
    edges     = 0;
    stall_cnt = stall_out ? 1 : 0;
    while (!valid_out && edges < 40) begin
      @(posedge clk); #1;
      edges++;
      if (stall_out) stall_cnt++;
    end
    valid_in = 1'b0;
    chk({tag, "/latency"}, 32'(edges), 32'(exp_lat));
    chk({tag, "/stall_cycles"}, 32'(stall_cnt), 32'(exp_lat));
    chk({tag, "/valid"}, 32'(valid_out), 32'd1);
    chk({tag, "/instr"}, instruction_out, instr);
    chk({tag, "/wb"}, wb_data, exp_wb);
    chk({tag, "/exc"}, 32'(exception_out), 32'(exp_exc));
    last_wb    = exp_wb;
    last_instr = instr;
    last_exc   = exp_exc;
  endtask

  // One cycle with no valid input: valid_out drops and the other outputs hold.
  task automatic idle_check(input string tag);
    valid_in = 1'b0;
    @(posedge clk); #1;
    chk({tag, "/valid"}, 32'(valid_out), 32'd0);
    chk({tag, "/stall"}, 32'(stall_out), 32'd0);
    chk({tag, "/wb_hold"}, wb_data, last_wb);
    chk({tag, "/instr_hold"}, instruction_out, last_instr);
    chk({tag, "/exc_hold"}, 32'(exception_out), 32'(last_exc));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [31:0] addr;
    int          kind;

    reset          = 1'b1;
    valid_in       = 1'b1;
    instruction_in = mk_instr(ALU, 3'b000);
    alu_result     = 32'hCAFE_0001;
    store_data     = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset/valid", 32'(valid_out), 32'd0);
    chk("reset/stall", 32'(stall_out), 32'd0);
    chk("reset/instr", instruction_out, 32'd0);
    chk("reset/wb", wb_data, 32'd0);
    chk("reset/exc", 32'(exception_out), 32'd0);
    reset    = 1'b0;
    valid_in = 1'b0;

    // Pass-through ADD straight out of reset.
    run_op("add", mk_instr(ALU, 3'b000), 32'h0000_1234, 32'd0);
    chk("add/const", wb_data, 32'h0000_1234);

    // Fill the memory so that every later load has a known answer.
    for (int i = 0; i < MEM_WORDS; i++) begin
      run_op("init", mk_instr(STORE, 3'b010), 32'(i * 4), $urandom);
    end

    run_op("sw10", mk_instr(STORE, 3'b010), 32'h10, 32'hDEAD_BEEF);
    run_op("lw10", mk_instr(LOAD, 3'b010), 32'h10, 32'd0);
    chk("lw10/const", wb_data, 32'hDEAD_BEEF);
    idle_check("hold");

    run_op("sb13", mk_instr(STORE, 3'b000), 32'h13, 32'hABCD_EF80);
    run_op("lb13", mk_instr(LOAD, 3'b000), 32'h13, 32'd0);
    chk("lb13/const", wb_data, 32'hFFFF_FF80);
    run_op("lbu13", mk_instr(LOAD, 3'b100), 32'h13, 32'd0);
    chk("lbu13/const", wb_data, 32'h0000_0080);
    run_op("lw10b", mk_instr(LOAD, 3'b010), 32'h10, 32'd0);
    chk("lw10b/upper", 32'(wb_data[31:24]), 32'h80);

    run_op("sw400", mk_instr(STORE, 3'b010), 32'h400, 32'h5);
    run_op("lw0", mk_instr(LOAD, 3'b010), 32'h0, 32'd0);
    chk("lw0/wrap", wb_data, 32'h5);

    run_op("lw2", mk_instr(LOAD, 3'b010), 32'h2, 32'd0);
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    chk("lw2/trap", 32'(exception_out), 32'd1);
`else
    chk("lw2/word0", wb_data, 32'h5);
`endif

    // Reset in the third busy cycle aborts the store.
    run_op("sw20pre", mk_instr(STORE, 3'b010), 32'h20, 32'h7);
    valid_in       = 1'b1;
    instruction_in = mk_instr(STORE, 3'b010);
    alu_result     = 32'h20;
    store_data     = 32'h1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("abort/busy", 32'(stall_out), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset    = 1'b0;
    valid_in = 1'b0;
    chk("abort/stall", 32'(stall_out), 32'd0);
    chk("abort/valid", 32'(valid_out), 32'd0);
    chk("abort/wb", wb_data, 32'd0);
    chk("abort/instr", instruction_out, 32'd0);
    for (int i = 0; i < MEM_LATENCY + 2; i++) begin
      @(posedge clk); #1;
      chk("abort/no_valid", 32'(valid_out), 32'd0);
    end
    run_op("lw20", mk_instr(LOAD, 3'b010), 32'h20, 32'd0);
    chk("lw20/const", wb_data, 32'h7);

    // Back-to-back pass-through, one result per cycle.
    for (int i = 0; i < 4; i++) begin
      run_op("b2b", mk_instr(ALU, 3'(i)), $urandom, 32'd0);
    end

    // Randomized traffic.
    for (int n = 0; n < 200; n++) begin
      kind = $urandom_range(0, 9);
      addr = (kind % 2 == 0) ? $urandom : 32'($urandom_range(0, 63));
      if (kind <= 2) begin
        op = 7'($urandom);
        if (op == LOAD || op == STORE) op = ALU;
        f3 = 3'($urandom);
      end else if (kind <= 5) begin
        op = LOAD;
        case ($urandom_range(0, 3))
          0: f3 = 3'b000;
          1: f3 = 3'b100;
          2: f3 = 3'b010;
          default: f3 = 3'($urandom);
        endcase
      end else begin
        op = STORE;
        case ($urandom_range(0, 2))
          0: f3 = 3'b000;
          1: f3 = 3'b010;
          default: f3 = 3'($urandom);
        endcase
      end
      run_op("rand", mk_instr(op, f3), addr, $urandom);
      if (kind == 9) idle_check("rand_idle");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
